// File: rtl/demux_dispatch_pkg.sv
// Shared types and helpers for the demux dispatcher slice.
package demux_dispatch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int lanes(input int sel_bits);
    return 1 << sel_bits;
  endfunction

endpackage

// File: rtl/demux_dispatcher_if.sv
// Producer stream plus per-lane handshake bundle of the demux dispatcher.
interface demux_dispatcher_if
  import demux_dispatch_pkg::*;
#(
  parameter int data_bits = 8,
  parameter int sel_bits  = 2
);
  localparam int n = lanes(sel_bits);

  logic                          in_valid;
  logic                          in_ready;
  logic [data_bits-1:0]          in_data;
  logic [n-1:0]                  out_valid;
  logic [n-1:0]                  out_ready;
  logic [n-1:0][data_bits-1:0]   data_out;
  logic [sel_bits-1:0]           sel;
  logic                          busy;

  // Slave is the dispatcher's view; master is the surrounding producer/consumers.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, data_out, sel, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, data_out, sel, busy
  );

endinterface

// File: rtl/demux.sv
// Combinational demultiplexer: the selected lane carries din, all other lanes are 0.
module demux
  import demux_dispatch_pkg::*;
#(
  parameter int data_bits = 8,
  parameter int sel_bits  = 2
)
(
  input  logic [data_bits-1:0]                        din,
  input  logic [sel_bits-1:0]                         sel,
  output logic [lanes(sel_bits)-1:0][data_bits-1:0]   dout
);

  always_comb begin
    dout      = '0;
    dout[sel] = din;
  end

endmodule

// File: rtl/demux_rr_pick.sv
// Lane chooser for the dispatcher. With DEMUX_DISPATCH_SKIP_EN it skips to the
// first ready lane at or after ptr; otherwise it is strict round-robin (ptr).
module demux_rr_pick
  import demux_dispatch_pkg::*;
#(
  parameter int sel_bits = 2
)
(
  input  logic [sel_bits-1:0]        ptr,
  input  logic [lanes(sel_bits)-1:0] ready,
  output logic [sel_bits-1:0]        pick
);

`ifdef DEMUX_DISPATCH_SKIP_EN
  logic [sel_bits-1:0] idx;
  logic                found;

  // Falls back to ptr when no lane is ready.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < lanes(sel_bits); i++) begin
      idx = ptr + sel_bits'(i);
      if (!found && ready[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
`else
  logic unused_ready;

  assign unused_ready = ^ready;
  assign pick         = ptr;
`endif

endmodule

// File: rtl/demux_dispatcher.sv
// Round-robin dispatcher: latches one producer word and steers it to a lane
// through the demux. Optional lane skipping via DEMUX_DISPATCH_SKIP_EN.
module demux_dispatcher
  import demux_dispatch_pkg::*;
#(
  parameter int data_bits = 8,
  parameter int sel_bits  = 2
)
(
  input  logic               clk,
  input  logic               rst_n,
  demux_dispatcher_if.slave  bus
);

  localparam int n = lanes(sel_bits);

  state_t                state;
  logic [sel_bits-1:0]   ptr;
  logic [sel_bits-1:0]   ptr_next;
  logic [sel_bits-1:0]   sel_q;
  logic [sel_bits-1:0]   pick;
  logic [data_bits-1:0]  hold_q;
  logic [n-1:0]          valid_dec;
  logic                  in_ready;
  logic                  done;
  logic                  accept;

  assign done     = (state == SEND) && bus.out_ready[sel_q];
  assign in_ready = (state == IDLE) || bus.out_ready[sel_q];
  assign accept   = bus.in_valid && in_ready;

  // A same-cycle reload must choose from the pointer as it stands after this completion.
  assign ptr_next = done ? (sel_q + sel_bits'(1)) : ptr;

  demux_rr_pick #(
    .sel_bits (sel_bits)
  ) u_pick (
    .ptr   (ptr_next),
    .ready (bus.out_ready),
    .pick  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      sel_q  <= '0;
      hold_q <= '0;
    end else begin
      ptr <= ptr_next;
      if (accept) begin
        hold_q <= bus.in_data;
        sel_q  <= pick;
        state  <= SEND;
      end else if (done) begin
        state  <= IDLE;
      end
    end
  end

  always_comb begin
    valid_dec = '0;
    if (state == SEND) valid_dec[sel_q] = 1'b1;
  end

  demux #(
    .data_bits (data_bits),
    .sel_bits  (sel_bits)
  ) u_demux (
    .din  (hold_q),
    .sel  (sel_q),
    .dout (bus.data_out)
  );

  assign bus.out_valid = valid_dec;
  assign bus.in_ready  = in_ready;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state == SEND);

endmodule
